// File: rtl/serdes_word_aligner.sv
`default_nettype none
// ============================================================================
// Module      : serdes_word_aligner
// Description : Locates the bit offset of a periodic sync word in the raw
//               deserializer output, confirms it over several frames, then
//               emits bit-aligned words with a start-of-frame marker. Loss of
//               alignment sends the aligner back to search automatically.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_word_aligner #(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN = 8'hBC,
  parameter int                    FRAME_LEN    = 16,
  parameter int                    LOCK_CNT     = 3,
  parameter int                    UNLOCK_CNT   = 2
) (
  input  logic                          pclk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         pdata_in,
  input  logic                          pdata_valid,
  output logic [DATA_WIDTH-1:0]         adata_out,
  output logic                          adata_valid,
  output logic                          adata_sof,
  output logic                          locked,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_offset,
  output logic                          sync_err
);

  localparam int c_off_w  = $clog2(DATA_WIDTH);
  localparam int c_fcnt_w = $clog2(FRAME_LEN);
  localparam int c_good_w = $clog2(LOCK_CNT + 1);
  localparam int c_miss_w = $clog2(UNLOCK_CNT + 1);

  localparam logic [c_fcnt_w-1:0] c_fcnt_last = c_fcnt_w'(FRAME_LEN - 1);
  localparam logic [c_good_w-1:0] c_good_lock = c_good_w'(LOCK_CNT);
  localparam logic [c_miss_w-1:0] c_miss_drop = c_miss_w'(UNLOCK_CNT);

  localparam logic [1:0] c_st_search = 2'd0;
  localparam logic [1:0] c_st_verify = 2'd1;
  localparam logic [1:0] c_st_locked = 2'd2;

  // Registered state
  logic [1:0]            state_q,       state_d;
  logic [DATA_WIDTH-1:0] prev_q,        prev_d;
  logic                  have_prev_q,   have_prev_d;
  logic [c_fcnt_w-1:0]   fcnt_q,        fcnt_d;
  logic [c_good_w-1:0]   good_cnt_q,    good_cnt_d;
  logic [c_miss_w-1:0]   miss_cnt_q,    miss_cnt_d;
  logic [c_off_w-1:0]    bit_offset_q,  bit_offset_d;
  logic [DATA_WIDTH-1:0] adata_out_q,   adata_out_d;
  logic                  adata_valid_q, adata_valid_d;
  logic                  adata_sof_q,   adata_sof_d;
  logic                  locked_q,      locked_d;
  logic                  sync_err_q,    sync_err_d;

  // Combinational helpers
  // The window omits the top bit of pdata_in: no offset below DATA_WIDTH
  // ever reaches it, so the current word contributes at most DATA_WIDTH-1 bits.
  logic [2*DATA_WIDTH-2:0] w_win;
  logic [DATA_WIDTH-1:0]   w_match_vec;
  logic                    w_hit;
  logic [c_off_w-1:0]      w_hit_off;
  logic [DATA_WIDTH-1:0]   w_cand;
  logic                    w_exp_sync;
  logic                    w_exp_match;
  logic                    w_sync_miss;
  logic [c_fcnt_w-1:0]     w_fcnt_next;

  assign w_win       = {pdata_in[DATA_WIDTH-2:0], prev_q};
  assign w_cand      = w_win[bit_offset_q +: DATA_WIDTH];
  assign w_exp_sync  = (fcnt_q == c_fcnt_last);
  assign w_exp_match = (w_cand == SYNC_PATTERN);
  assign w_fcnt_next = w_exp_sync ? '0 : fcnt_q + 1'b1;
  assign w_sync_miss = pdata_valid && w_exp_sync && !w_exp_match &&
                       ((state_q == c_st_verify) || (state_q == c_st_locked));

  // One sync comparator per candidate bit offset
  generate
    for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_cand
      assign w_match_vec[k] = (w_win[k +: DATA_WIDTH] == SYNC_PATTERN);
    end
  endgenerate

  // Priority pick of the lowest matching offset (scan downward, last hit wins)
  always_comb begin
    w_hit     = 1'b0;
    w_hit_off = '0;
    for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
      if (w_match_vec[k]) begin
        w_hit     = 1'b1;
        w_hit_off = k[c_off_w-1:0];
      end
    end
  end

  // State register: all flops, async clear
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= c_st_search;
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
      fcnt_q        <= '0;
      good_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      bit_offset_q  <= '0;
      adata_out_q   <= '0;
      adata_valid_q <= 1'b0;
      adata_sof_q   <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      have_prev_q   <= have_prev_d;
      fcnt_q        <= fcnt_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      bit_offset_q  <= bit_offset_d;
      adata_out_q   <= adata_out_d;
      adata_valid_q <= adata_valid_d;
      adata_sof_q   <= adata_sof_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  // Next-state: search / verify / locked transitions and frame bookkeeping
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    have_prev_d  = have_prev_q;
    fcnt_d       = fcnt_q;
    good_cnt_d   = good_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    bit_offset_d = bit_offset_q;
    if (pdata_valid) begin
      prev_d      = pdata_in;
      have_prev_d = 1'b1;
      fcnt_d      = w_fcnt_next;
      case (state_q)
        c_st_search: begin
          if (have_prev_q && w_hit) begin
            bit_offset_d = w_hit_off;
            good_cnt_d   = c_good_w'(1);
            miss_cnt_d   = '0;
            fcnt_d       = '0;
            state_d      = (LOCK_CNT == 1) ? c_st_locked : c_st_verify;
          end
        end
        c_st_verify: begin
          if (w_exp_sync) begin
            if (w_exp_match) begin
              good_cnt_d = good_cnt_q + 1'b1;
              if (good_cnt_q + 1'b1 == c_good_lock) begin
                state_d    = c_st_locked;
                miss_cnt_d = '0;
              end
            end else begin
              state_d = c_st_search;
            end
          end
        end
        c_st_locked: begin
          if (w_exp_sync) begin
            if (w_exp_match) begin
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
              if (miss_cnt_q + 1'b1 == c_miss_drop) begin
                state_d = c_st_search;
              end
            end
          end
        end
        default: state_d = c_st_search;
      endcase
    end
  end

  // Outputs: aligned word only for words processed while already locked
  always_comb begin
    adata_out_d   = adata_out_q;
    adata_valid_d = 1'b0;
    adata_sof_d   = 1'b0;
    sync_err_d    = 1'b0;
    locked_d      = (state_d == c_st_locked);
    if (pdata_valid) begin
      sync_err_d = w_sync_miss;
      if (state_q == c_st_locked) begin
        adata_valid_d = 1'b1;
        adata_out_d   = w_cand;
        adata_sof_d   = w_exp_sync && w_exp_match;
      end
    end
  end

  assign adata_out   = adata_out_q;
  assign adata_valid = adata_valid_q;
  assign adata_sof   = adata_sof_q;
  assign locked      = locked_q;
  assign bit_offset  = bit_offset_q;
  assign sync_err    = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_serdes_word_aligner.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdes_word_aligner
// Description : Directed self-checking bench for serdes_word_aligner. Builds
//               an aligned frame stream, slips it by 3 bits into raw words and
//               checks lock, data, sof, sync_err, gaps and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_word_aligner;

  localparam int SLIP = 3;
  localparam int N_AL = 336;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic [7:0] pdata_in;
  logic       pdata_valid;
  logic [7:0] adata_out;
  logic       adata_valid;
  logic       adata_sof;
  logic       locked;
  logic [2:0] bit_offset;
  logic       sync_err;

  int chk_cnt = 0;
  int err_cnt = 0;
  int sync_err_seen;
  int valid_seen;

  logic [7:0] al [0:N_AL-1];

  serdes_word_aligner dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .pdata_in    (pdata_in),
    .pdata_valid (pdata_valid),
    .adata_out   (adata_out),
    .adata_valid (adata_valid),
    .adata_sof   (adata_sof),
    .locked      (locked),
    .bit_offset  (bit_offset),
    .sync_err    (sync_err)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raw word m carries aligned bits so that the window at input m, offset
  // SLIP, reproduces aligned word m.
  function automatic logic [7:0] raw_of(input int idx);
    logic [15:0] pair;
    pair = {al[idx+1], al[idx]};
    pair = pair >> (8 - SLIP);
    return pair[7:0];
  endfunction

  task automatic send_word(input logic [7:0] b);
    pdata_in    = b;
    pdata_valid = 1'b1;
    @(posedge pclk);
    #1;
    pdata_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    pdata_valid = 1'b0;
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out"},    {24'd0, adata_out}, 32'd0);
    check_eq({tag, "_valid"},  {31'd0, adata_valid}, 32'd0);
    check_eq({tag, "_sof"},    {31'd0, adata_sof}, 32'd0);
    check_eq({tag, "_locked"}, {31'd0, locked}, 32'd0);
    check_eq({tag, "_offset"}, {29'd0, bit_offset}, 32'd0);
    check_eq({tag, "_serr"},   {31'd0, sync_err}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    pdata_valid = 1'b0;
    pdata_in    = 8'h00;

    // Aligned stream: filler, then 16-word frames BC,01..0F
    al[0] = 8'h00;
    for (int i = 1; i < N_AL; i++) begin
      al[i] = (((i - 1) % 16) == 0) ? 8'hBC : 8'((i - 1) % 16);
    end
    al[65]  = 8'h00;  // single missed sync while locked
    al[97]  = 8'h00;  // single missed sync after a clean frame
    al[129] = 8'h00;  // first of two consecutive misses
    al[145] = 8'h00;  // second miss -> unlock
    al[230] = 8'hF0;  // with 231 forms BC at offset 5 mid-frame
    al[231] = 8'h02;
    al[273] = 8'h00;  // second sync missed during verify

    repeat (3) @(posedge pclk);
    #1;
    check_all_zero("rst");
    @(negedge pclk);
    rst_n = 1'b1;
    idle_cycles(3);
    check_all_zero("idle");

    repeat (5) begin
      send_word(8'h00);
      check_eq("zero_locked", {31'd0, locked}, 32'd0);
      check_eq("zero_valid",  {31'd0, adata_valid}, 32'd0);
    end

    // Acquire, lock, single misses, double miss, relock
    sync_err_seen = 0;
    valid_seen    = 0;
    for (int idx = 0; idx <= 208; idx++) begin
      send_word(raw_of(idx));
      sync_err_seen += int'(sync_err);
      valid_seen    += int'(adata_valid);
      if (idx == 1) begin
        check_eq("hit_offset", {29'd0, bit_offset}, 32'd3);
        check_eq("hit_locked", {31'd0, locked}, 32'd0);
      end
      if (idx == 32) check_eq("pre_lock", {31'd0, locked}, 32'd0);
      if (idx == 33) begin
        check_eq("lock_rise",  {31'd0, locked}, 32'd1);
        check_eq("lock_valid", {31'd0, adata_valid}, 32'd0);
      end
      if (idx >= 34 && idx <= 48) begin
        check_eq("pay_valid", {31'd0, adata_valid}, 32'd1);
        check_eq("pay_data",  {24'd0, adata_out}, {24'd0, al[idx]});
        check_eq("pay_sof",   {31'd0, adata_sof}, 32'd0);
      end
      if (idx == 49) begin
        check_eq("sync_data", {24'd0, adata_out}, 32'hBC);
        check_eq("sync_sof",  {31'd0, adata_sof}, 32'd1);
      end
      if (idx == 65) begin
        check_eq("miss1_err",    {31'd0, sync_err}, 32'd1);
        check_eq("miss1_locked", {31'd0, locked}, 32'd1);
        check_eq("miss1_data",   {24'd0, adata_out}, 32'h00);
        check_eq("miss1_sof",    {31'd0, adata_sof}, 32'd0);
      end
      if (idx == 66) check_eq("err_pulse", {31'd0, sync_err}, 32'd0);
      if (idx == 81) check_eq("clean_sof", {31'd0, adata_sof}, 32'd1);
      if (idx == 97) begin
        check_eq("miss2_err",    {31'd0, sync_err}, 32'd1);
        check_eq("miss2_locked", {31'd0, locked}, 32'd1);
      end
      if (idx == 129) check_eq("dbl1_locked", {31'd0, locked}, 32'd1);
      if (idx == 145) begin
        check_eq("dbl2_err",    {31'd0, sync_err}, 32'd1);
        check_eq("dbl2_locked", {31'd0, locked}, 32'd0);
        check_eq("dbl2_valid",  {31'd0, adata_valid}, 32'd1);
      end
      if (idx == 146) check_eq("srch_valid", {31'd0, adata_valid}, 32'd0);
      if (idx == 192) check_eq("relock_pre", {31'd0, locked}, 32'd0);
      if (idx == 193) begin
        check_eq("relock",       {31'd0, locked}, 32'd1);
        check_eq("relock_valid", {31'd0, adata_valid}, 32'd0);
      end
      if (idx == 194) check_eq("relock_data", {24'd0, adata_out}, 32'h01);
    end
    check_eq("serr_total",  sync_err_seen, 32'd4);
    check_eq("valid_total", valid_seen, 32'd127);

    // Locked stream with random idle gaps, plus a mid-frame BC at offset 5
    for (int idx = 209; idx <= 240; idx++) begin
      idle_cycles($urandom_range(1, 4));
      check_eq("gap_valid", {31'd0, adata_valid}, 32'd0);
      send_word(raw_of(idx));
      check_eq("gap_wvalid", {31'd0, adata_valid}, 32'd1);
      check_eq("gap_data",   {24'd0, adata_out}, {24'd0, al[idx]});
      check_eq("gap_sof",    {31'd0, adata_sof}, {31'd0, (((idx - 1) % 16) == 0)});
      check_eq("gap_serr",   {31'd0, sync_err}, 32'd0);
      if (idx == 230) check_eq("stray_offset", {29'd0, bit_offset}, 32'd3);
    end
    for (int idx = 241; idx <= 244; idx++) begin
      send_word(raw_of(idx));
      if (idx == 241) check_eq("post_gap_sof", {31'd0, adata_sof}, 32'd1);
    end

    // Asynchronous mid-frame reset
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge pclk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Full re-acquire with a verify failure on the way
    valid_seen = 0;
    for (int idx = 250; idx <= 330; idx++) begin
      send_word(raw_of(idx));
      if (idx <= 321) valid_seen += int'(adata_valid);
      if (idx == 256) check_eq("rr_offset0", {29'd0, bit_offset}, 32'd0);
      if (idx == 257) begin
        check_eq("rr_hit_offset", {29'd0, bit_offset}, 32'd3);
        check_eq("rr_hit_locked", {31'd0, locked}, 32'd0);
      end
      if (idx == 273) check_eq("vfy_err", {31'd0, sync_err}, 32'd1);
      if (idx == 274) check_eq("vfy_err_pulse", {31'd0, sync_err}, 32'd0);
      if (idx == 305) check_eq("rr_pre_lock", {31'd0, locked}, 32'd0);
      if (idx == 321) check_eq("rr_lock", {31'd0, locked}, 32'd1);
      if (idx == 322) begin
        check_eq("rr_valid", {31'd0, adata_valid}, 32'd1);
        check_eq("rr_data",  {24'd0, adata_out}, 32'h01);
      end
    end
    check_eq("rr_no_valid", valid_seen, 32'd0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
